// File: rtl/banco_registros_pkg.sv
`default_nettype none
// ============================================================================
// Module      : banco_registros_pkg
// Description : Shared sizes and types for the RV32-style integer register
//               file (banco_registros_rv) and its read-port mux.
//               Contents:
//                 DATA_W      width of one register / data port
//                 ADDR_W      register address width
//                 NREGS       number of architectural registers (2**ADDR_W)
//                 word_t      one register word
//                 reg_addr_t  one register address
//                 REG_ZERO    address of the hardwired-zero register x0
// Revision    : 1.0 - initial release
// ============================================================================
package banco_registros_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    // x0 reads as zero and is never stored
    localparam reg_addr_t REG_ZERO = '0;

    // True when a write to this address actually updates storage
    function automatic logic is_storable(input reg_addr_t addr);
        return (addr != REG_ZERO);
    endfunction

endpackage : banco_registros_pkg
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
// Module      : regfile_read_port
// Description : One combinational read port of the register file.
//               Selects a stored word by address, forces x0 to zero and,
//               when BANCO_REGISTROS_BYPASS_EN is defined, forwards the
//               word being written in the same cycle (write-through).
//               Ports:
//                 read_addr   in   register address to read
//                 write_en    in   write enable of the shared write port
//                 write_addr  in   write-port address
//                 write_data  in   write-port data
//                 regs        in   storage array contents
//                 read_data   out  selected register value
//               Configuration macro: BANCO_REGISTROS_BYPASS_EN
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_port
    import banco_registros_pkg::*;
(
    input  reg_addr_t read_addr,
    input  logic      write_en,
    input  reg_addr_t write_addr,
    input  word_t     write_data,
    input  word_t     regs [NREGS],
    output word_t     read_data
);

    word_t w_read_data;

`ifdef BANCO_REGISTROS_BYPASS_EN
    logic w_bypass_hit;

    // A write to x0 never forwards; x0 is masked below anyway, but keeping
    // the hit clean makes the intent explicit.
    assign w_bypass_hit = write_en && is_storable(write_addr) &&
                          (write_addr == read_addr);
`else
    // Write-port signals are only needed for forwarding.
    logic w_unused_bypass;
    assign w_unused_bypass = write_en ^ (^write_addr) ^ (^write_data);
`endif

    always_comb begin
        w_read_data = regs[read_addr];
`ifdef BANCO_REGISTROS_BYPASS_EN
        if (w_bypass_hit) begin
            w_read_data = write_data;
        end
`endif
        // x0 masking has the last word so it wins over forwarding.
        if (read_addr == REG_ZERO) begin
            w_read_data = '0;
        end
    end

    assign read_data = w_read_data;

endmodule : regfile_read_port
`default_nettype wire

// File: rtl/banco_registros_rv.sv
`default_nettype none
// ============================================================================
// Module      : banco_registros_rv
// Description : RV32-style integer register file: 32 x 32-bit registers,
//               two asynchronous read ports and one synchronous write port.
//               x0 is hardwired to zero. Sits between decode and the
//               ALU / writeback stages.
//               Ports:
//                 CLK        in   clock, writes on the rising edge
//                 RST_n      in   asynchronous active-low reset, clears all
//                 readReg1   in   read port 1 address
//                 readReg2   in   read port 2 address
//                 writeReg   in   write port address
//                 writeData  in   write port data
//                 RegWrite   in   write enable, active high
//                 readData1  out  contents of register readReg1
//                 readData2  out  contents of register readReg2
//               Configuration macro: BANCO_REGISTROS_BYPASS_EN
//                 defined   -> same-cycle write-through forwarding
//                 undefined -> reads return the stored (old) value
// Revision    : 1.0 - initial release
// ============================================================================
module banco_registros_rv
    import banco_registros_pkg::*;
(
    input  logic      CLK,
    input  logic      RST_n,
    input  reg_addr_t readReg1,
    input  reg_addr_t readReg2,
    input  reg_addr_t writeReg,
    input  word_t     writeData,
    input  logic      RegWrite,
    output word_t     readData1,
    output word_t     readData2
);

    // ------------------------------------------------------------------
    // Storage. Entry 0 is only ever cleared by reset; the read ports mask
    // it regardless, so it never needs to be written.
    // ------------------------------------------------------------------
    word_t r_regs [NREGS];

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (RegWrite && is_storable(writeReg)) begin
            r_regs[writeReg] <= writeData;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    regfile_read_port u_read_port1 (
        .read_addr  (readReg1),
        .write_en   (RegWrite),
        .write_addr (writeReg),
        .write_data (writeData),
        .regs       (r_regs),
        .read_data  (readData1)
    );

    regfile_read_port u_read_port2 (
        .read_addr  (readReg2),
        .write_en   (RegWrite),
        .write_addr (writeReg),
        .write_data (writeData),
        .regs       (r_regs),
        .read_data  (readData2)
    );

endmodule : banco_registros_rv
`default_nettype wire

// File: tb/tb_banco_registros_rv.sv
`default_nettype none
// ============================================================================
// Module      : tb_banco_registros_rv
// Description : Self-checking bench for banco_registros_rv. A table of
//               directed vectors is applied one per clock (reads compared
//               just before the write edge), followed by hand-written
//               sequences for same-cycle read/write and mid-cycle reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_banco_registros_rv;

    logic        CLK;
    logic        RST_n;
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        RegWrite;
    logic [31:0] readData1;
    logic [31:0] readData2;

    int checks = 0;
    int errors = 0;

    banco_registros_rv dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .readReg1  (readReg1),
        .readReg2  (readReg2),
        .writeReg  (writeReg),
        .writeData (writeData),
        .RegWrite  (RegWrite),
        .readData1 (readData1),
        .readData2 (readData2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, actual=running required=done");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] r1,
                         input logic [4:0] r2);
        RegWrite  = we;
        writeReg  = wa;
        writeData = wd;
        readReg1  = r1;
        readReg2  = r2;
    endtask

    logic [31:0] exp_same;

    initial begin
        // Expected reads are the values visible before each vector's edge.
        vecs[0]  = '{1'b1, 5'd0,  32'h0000_00A1, 5'd0,  5'd0,  32'h0,         32'h0};
        vecs[1]  = '{1'b1, 5'd0,  32'h0000_00A1, 5'd0,  5'd0,  32'h0,         32'h0};
        vecs[2]  = '{1'b1, 5'd13, 32'h0000_A234, 5'd0,  5'd1,  32'h0,         32'h0};
        vecs[3]  = '{1'b1, 5'd16, 32'h0000_1234, 5'd13, 5'd0,  32'h0000_A234, 32'h0};
        vecs[4]  = '{1'b1, 5'd24, 32'h0000_2345, 5'd13, 5'd13, 32'h0000_A234, 32'h0000_A234};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,         5'd16, 5'd24, 32'h0000_1234, 32'h0000_2345};
        vecs[6]  = '{1'b1, 5'd7,  32'h0000_0777, 5'd24, 5'd16, 32'h0000_2345, 32'h0000_1234};
        vecs[7]  = '{1'b0, 5'd7,  32'hFFFF_FFFF, 5'd7,  5'd7,  32'h0000_0777, 32'h0000_0777};
        vecs[8]  = '{1'b0, 5'd7,  32'hFFFF_FFFF, 5'd7,  5'd0,  32'h0000_0777, 32'h0};
        vecs[9]  = '{1'b1, 5'd31, 32'h8000_0001, 5'd30, 5'd1,  32'h0,         32'h0};
        vecs[10] = '{1'b0, 5'd0,  32'h0,         5'd31, 5'd31, 32'h8000_0001, 32'h8000_0001};

        // ---------------- reset, with a write request held -------------
        RST_n = 1'b0;
        drive(1'b1, 5'd13, 32'hCAFE_F00D, 5'd13, 5'd31);
        repeat (2) @(posedge CLK);
        #1;
        check("reset_rd1", readData1, 32'h0);
        check("reset_rd2", readData2, 32'h0);
        @(negedge CLK);
        RST_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd13, 5'd31);
        #1;
        check("post_reset_x13", readData1, 32'h0);

        // ---------------- table-driven vectors -------------------------
        for (int i = 0; i < NVEC; i++) begin
            @(negedge CLK);
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].r1, vecs[i].r2);
            #1;
            check($sformatf("vec%0d_rd1", i), readData1, vecs[i].e1);
            check($sformatf("vec%0d_rd2", i), readData2, vecs[i].e2);
        end

        // ---------------- same-cycle read/write of x9 ------------------
        @(negedge CLK);
        drive(1'b1, 5'd9, 32'h0000_0011, 5'd0, 5'd0);
        @(negedge CLK);
        drive(1'b1, 5'd9, 32'h0000_0055, 5'd9, 5'd9);
`ifdef BANCO_REGISTROS_BYPASS_EN
        exp_same = 32'h0000_0055;
`else
        exp_same = 32'h0000_0011;
`endif
        #1;
        check("x9_same_cycle_rd1", readData1, exp_same);
        check("x9_same_cycle_rd2", readData2, exp_same);
        @(posedge CLK);
        #1;
        RegWrite = 1'b0;
        #1;
        check("x9_after_edge", readData1, 32'h0000_0055);

        // Write to x0 with x0 on both ports: always zero, bypass or not
        @(negedge CLK);
        drive(1'b1, 5'd0, 32'h0000_00A1, 5'd0, 5'd0);
        #1;
        check("x0_write_same_cycle", readData1, 32'h0);

        // Address change within a cycle, no edge in between
        @(negedge CLK);
        drive(1'b0, 5'd0, 32'h0, 5'd16, 5'd7);
        #1;
        check("comb_rd1_a", readData1, 32'h0000_1234);
        readReg1 = 5'd24;
        #1;
        check("comb_rd1_b", readData1, 32'h0000_2345);
        check("x7_kept", readData2, 32'h0000_0777);

        // ---------------- mid-cycle asynchronous reset -----------------
        @(negedge CLK);
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0);
        @(negedge CLK);
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
        #1;
        check("x5_written", readData1, 32'hDEAD_BEEF);
        #1;
        RST_n = 1'b0;
        #1;
        check("async_reset_x5", readData1, 32'h0);
        check("async_reset_x31", readData2, 32'h0);
        // Write attempted across an edge while reset is held
        drive(1'b1, 5'd6, 32'h0000_0123, 5'd5, 5'd6);
        @(posedge CLK);
        #1;
        check("write_in_reset", readData2, 32'h0);
        @(negedge CLK);
        #2;
        RST_n = 1'b1;
        RegWrite = 1'b0;
        #1;
        check("after_release_x6", readData2, 32'h0);
        @(negedge CLK);
        drive(1'b1, 5'd6, 32'h0000_0123, 5'd5, 5'd13);
        @(posedge CLK);
        #1;
        RegWrite = 1'b0;
        readReg2 = 5'd6;
        #1;
        check("first_write_after_release", readData2, 32'h0000_0123);
        readReg2 = 5'd13;
        #1;
        check("x13_cleared", readData2, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_banco_registros_rv
`default_nettype wire
